// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file with busy scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int N_READ_MAX = 4;
  localparam int IDX_W_MAX  = 16;
  localparam int PORT_BUS_W = N_READ_MAX * IDX_W_MAX;

  // Extracts the index of one read port from a zero-extended packed index bus.
  function automatic logic [IDX_W_MAX-1:0] port_slice(
    input logic [PORT_BUS_W-1:0] bus,
    input int unsigned           port,
    input int unsigned           width
  );
    logic [PORT_BUS_W-1:0] shifted;
    shifted = bus >> (port * width);
    return shifted[IDX_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the ID/WB stages (master) and the register file (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_READ = 2
);

  logic                       regWrite;
  logic [ADDR_W-1:0]          writeReg;
  logic [DATA_W-1:0]          writeData;
  logic [N_READ*ADDR_W-1:0]   readReg;
  logic [N_READ*DATA_W-1:0]   readData;
  logic [N_READ-1:0]          readBusy;
  logic                       busySet;
  logic [ADDR_W-1:0]          busyReg;
  logic [ADDR_W-1:0]          dbgReg;
  logic [DATA_W-1:0]          dbgData;

  modport master (
    output regWrite, writeReg, writeData, readReg, busySet, busyReg, dbgReg,
    input  readData, readBusy, dbgData
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg, busySet, busyReg, dbgReg,
    output readData, readBusy, dbgData
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: array mux, register-0 masking and optional
// write-through bypass (enabled by defining REGFILE_BYPASS_EN).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]    rd_addr_i,
  input  logic [DATA_W-1:0]    regs_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic                 set_en_i,
  input  logic [ADDR_W-1:0]    set_addr_i,
  output logic [DATA_W-1:0]    rd_data_o,
  output logic                 rd_busy_o
);

  logic              zero_hit_s;
  logic [DATA_W-1:0] arr_data_s;
  logic              arr_busy_s;

  assign zero_hit_s = (ZERO_REG != 0) && (rd_addr_i == {ADDR_W{1'b0}});

  // Array lookup with register 0 forced to read as zero and never busy.
  always_comb begin
    arr_data_s = {DATA_W{1'b0}};
    arr_busy_s = 1'b0;
    if (zero_hit_s) begin
      arr_data_s = {DATA_W{1'b0}};
      arr_busy_s = 1'b0;
    end else begin
      arr_data_s = regs_i[rd_addr_i];
      arr_busy_s = busy_i[rd_addr_i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_hit_s;
  logic set_hit_s;

  // wr_en_i/set_en_i arrive already masked for reset and register 0.
  assign wr_hit_s  = wr_en_i && (wr_addr_i == rd_addr_i);
  assign set_hit_s = set_en_i && (set_addr_i == rd_addr_i);

  // Write-through: a same-cycle writeback wins, a same-cycle new producer keeps it busy.
  always_comb begin
    rd_data_o = arr_data_s;
    rd_busy_o = arr_busy_s;
    if (wr_hit_s) begin
      rd_data_o = wr_data_i;
      rd_busy_o = set_hit_s;
    end else begin
      rd_data_o = arr_data_s;
      rd_busy_o = arr_busy_s;
    end
  end
`else
  logic unused_bypass_s;

  assign unused_bypass_s = ^{wr_en_i, wr_addr_i, wr_data_i, set_en_i, set_addr_i};

  // Without bypass the port returns array contents only.
  always_comb begin
    rd_data_o = arr_data_s;
    rd_busy_o = arr_busy_s;
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register write-pending busy bits.
// Optional write-through bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rstN,
  regfile_mp_if.slave  rf
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic                     wr_en_s;
  logic                     set_en_s;
  logic [DATA_W-1:0]        rd_data_s [N_READ];
  logic [N_READ-1:0]        rd_busy_s;
  logic [N_READ*DATA_W-1:0] rd_bus_s;

  // Qualified write/set enables; gating with rstN keeps the bypass silent under reset.
  always_comb begin
    wr_en_s  = 1'b0;
    set_en_s = 1'b0;
    if (rstN) begin
      wr_en_s  = rf.regWrite &&
                 !((ZERO_REG != 0) && (rf.writeReg == {ADDR_W{1'b0}}));
      set_en_s = rf.busySet &&
                 !((ZERO_REG != 0) && (rf.busyReg == {ADDR_W{1'b0}}));
    end else begin
      wr_en_s  = 1'b0;
      set_en_s = 1'b0;
    end
  end

  // Next array state; the busy set is applied last so a new producer wins over writeback.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en_s) begin
      regs_d[rf.writeReg] = rf.writeData;
      busy_d[rf.writeReg] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_en_s) begin
      busy_d[rf.busyReg] = 1'b1;
    end else begin
      regs_d = regs_d;
    end
  end

  // Register and busy arrays.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      busy_q <= {DEPTH{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr_s;

    assign rd_addr_s = ADDR_W'(port_slice(PORT_BUS_W'(rf.readReg), k, ADDR_W));

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .rd_addr_i  (rd_addr_s),
      .regs_i     (regs_q),
      .busy_i     (busy_q),
      .wr_en_i    (wr_en_s),
      .wr_addr_i  (rf.writeReg),
      .wr_data_i  (rf.writeData),
      .set_en_i   (set_en_s),
      .set_addr_i (rf.busyReg),
      .rd_data_o  (rd_data_s[k]),
      .rd_busy_o  (rd_busy_s[k])
    );
  end

  // Pack per-port results onto the read data bus.
  always_comb begin
    rd_bus_s = {(N_READ*DATA_W){1'b0}};
    for (int k = 0; k < N_READ; k++) begin
      rd_bus_s[k*DATA_W +: DATA_W] = rd_data_s[k];
    end
  end

  assign rf.readData = rd_bus_s;
  assign rf.readBusy = rd_busy_s;
  assign rf.dbgData  = regs_q[rf.dbgReg];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (default 32x32x2 and a 16x16x4 instance).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rstN;
  int   checks;
  int   errors;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .N_READ(2)) rf ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .N_READ(4)) rf4 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1)) u_dut (
    .clk  (clk),
    .rstN (rstN),
    .rf   (rf)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .N_READ(4), .ZERO_REG(1)) u_dut4 (
    .clk  (clk),
    .rstN (rstN),
    .rf   (rf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        bs;
    logic [4:0]  breg;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_b0;
    logic        e_b1;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic bs, input logic [4:0] breg,
                       input logic [4:0] r0, input logic [4:0] r1);
    rf.regWrite  = we;
    rf.writeReg  = wreg;
    rf.writeData = wdata;
    rf.busySet   = bs;
    rf.busyReg   = breg;
    rf.readReg   = {r1, r0};
    rf.dbgReg    = r0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  idx4 [4];
  logic [15:0] exp4 [4];

  initial begin
    checks = 0;
    errors = 0;
    rstN   = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    rf4.regWrite = 1'b0; rf4.writeReg = 4'd0; rf4.writeData = 16'h0;
    rf4.busySet = 1'b0; rf4.busyReg = 4'd0; rf4.readReg = 16'h0; rf4.dbgReg = 4'd0;

    //          we    wreg   wdata         bs    breg   r0     r1     e_d0          e_d1          b0    b1
    vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd1,  5'd2,  32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd7,  5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd0,  5'd7,  32'h0,        32'h12345678, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd9,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'h0,        1'b0, 1'b1};
    vecs[5]  = '{1'b1, 5'd9,  32'h00000055, 1'b0, 5'd0,  5'd7,  5'd1,  32'h12345678, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h00000055, 32'h00000055, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd4,  32'h00000077, 1'b1, 5'd4,  5'd7,  5'd9,  32'h12345678, 32'h00000055, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd4,  32'h00000077, 32'h00000077, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd0,  5'd4,  5'd5,  32'h00000077, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd4,  32'hCAFEF00D, 32'h00000077, 1'b0, 1'b1};

    // Reset state, both instances.
    #3;
    check("rst_rd", rf.readData, 64'h0);
    check("rst_busy", rf.readBusy, 64'h0);
    check("rst_dbg", rf.dbgData, 64'h0);
    check("rst4_dbg", rf4.dbgData, 64'h0);
    @(negedge clk);
    rstN = 1'b1;
    next_cycle();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].bs, vecs[i].breg,
            vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      check($sformatf("v%0d_rd0", i), rf.readData[31:0], vecs[i].e_d0);
      check($sformatf("v%0d_rd1", i), rf.readData[63:32], vecs[i].e_d1);
      check($sformatf("v%0d_bz0", i), rf.readBusy[0], vecs[i].e_b0);
      check($sformatf("v%0d_bz1", i), rf.readBusy[1], vecs[i].e_b1);
      check($sformatf("v%0d_dbg", i), rf.dbgData, vecs[i].e_d0);
      next_cycle();
    end

    // Same-cycle write/read of r3: bypass shows it before the edge, dbg never does.
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd3);
    @(negedge clk);
    check("byp_rd1_pre", rf.readData[63:32], BYP ? 32'hA5A5A5A5 : 32'h0);
    check("byp_dbg_pre", rf.dbgData, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    @(negedge clk);
    check("byp_rd1_post", rf.readData[63:32], 32'hA5A5A5A5);
    check("byp_dbg_post", rf.dbgData, 32'hA5A5A5A5);
    next_cycle();

    // Busy set latency, then writeback clearing it.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 5'd0);
    @(negedge clk);
    check("bz_set_same", rf.readBusy[0], 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    @(negedge clk);
    check("bz_set_next", rf.readBusy[0], 1'b1);
    next_cycle();
    drive(1'b1, 5'd10, 32'h1, 1'b0, 5'd0, 5'd10, 5'd0);
    @(negedge clk);
    check("bz_clr_same", rf.readBusy[0], BYP ? 1'b0 : 1'b1);
    check("bz_clr_rd", rf.readData[31:0], BYP ? 32'h1 : 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    @(negedge clk);
    check("bz_clr_next", rf.readBusy[0], 1'b0);
    next_cycle();

    // Simultaneous writeback and new producer on r11, seen through the bypass.
    drive(1'b1, 5'd11, 32'h2, 1'b1, 5'd11, 5'd11, 5'd0);
    @(negedge clk);
    check("setwr_bz_same", rf.readBusy[0], BYP ? 1'b1 : 1'b0);
    check("setwr_rd_same", rf.readData[31:0], BYP ? 32'h2 : 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd11, 5'd0);
    @(negedge clk);
    check("setwr_bz_next", rf.readBusy[0], 1'b1);
    check("setwr_rd_next", rf.readData[31:0], 32'h2);
    next_cycle();

    // Asynchronous reset with write/set inputs active.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd5, 5'd6);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    @(negedge clk);
    check("pre_rst_dbg", rf.dbgData, 32'hDEADBEEF);
    check("pre_rst_bz1", rf.readBusy[1], 1'b1);
    drive(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 5'd5, 5'd6);
    #1;
    rstN = 1'b0;
    #1;
    check("rst_async_dbg", rf.dbgData, 32'h0);
    check("rst_async_rd", rf.readData, 64'h0);
    check("rst_async_bz", rf.readBusy, 64'h0);
    next_cycle();
    check("rst_hold_rd", rf.readData, 64'h0);
    check("rst_hold_dbg", rf.dbgData, 32'h0);
    drive(1'b1, 5'd5, 32'h9, 1'b0, 5'd0, 5'd5, 5'd6);
    rstN = 1'b1;
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    @(negedge clk);
    check("rel_first_wr", rf.dbgData, 32'h9);
    check("rel_bz", rf.readBusy, 64'h0);
    next_cycle();

    // Four-port 16-bit instance.
    rf4.regWrite = 1'b1; rf4.writeReg = 4'd15; rf4.writeData = 16'hBEEF;
    next_cycle();
    rf4.writeReg = 4'd3; rf4.writeData = 16'h1234;
    next_cycle();
    rf4.writeReg = 4'd0; rf4.writeData = 16'hFFFF;
    next_cycle();
    rf4.regWrite = 1'b0;
    idx4[0] = 4'd15; idx4[1] = 4'd3; idx4[2] = 4'd0; idx4[3] = 4'd15;
    exp4[0] = 16'hBEEF; exp4[1] = 16'h1234; exp4[2] = 16'h0; exp4[3] = 16'hBEEF;
    for (int pass = 0; pass < 2; pass++) begin
      rf4.readReg = {idx4[3], idx4[2], idx4[1], idx4[0]};
      for (int k = 0; k < 4; k++) begin
        rf4.dbgReg = idx4[k];
        #1;
        check($sformatf("p%0d_port%0d", pass, k), rf4.readData[k*16 +: 16], exp4[k]);
        check($sformatf("p%0d_dbg%0d", pass, k), rf4.dbgData, exp4[k]);
      end
      for (int k = 0; k < 4; k++) begin
        idx4[k] = 4'd15;
        exp4[k] = 16'hBEEF;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with an integrated write-pending scoreboard for the pipelined CPU. It has `N_READ` combinational read ports and one synchronous write port, and register 0 is optionally hard-wired to zero. Each register carries a busy bit that is set when a producer issues and cleared on writeback, so the hazard unit can stall without tracking destinations itself. It sits between ID (reads, busy query, busy set) and WB (write).

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: index width; depth = 2**ADDR_W.
- `N_READ`, 2: number of read ports (1..4).
- `ZERO_REG`, 1: 1 = register 0 reads as 0 and ignores writes and busy sets.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstN`  in  1  asynchronous active-low reset.
- `regWrite`  in  1  write enable.
- `writeReg`  in  ADDR_W  write index.
- `writeData`  in  DATA_W  write data.
- `readReg`  in  N_READ*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- `readData`  out  N_READ*DATA_W  read data, packed the same way as `readReg`.
- `readBusy`  out  N_READ  busy flag of each read port's register.
- `busySet`  in  1  marks `busyReg` as having a pending write.
- `busyReg`  in  ADDR_W  register to mark busy.
- `dbgReg`  in  ADDR_W  debug read index.
- `dbgData`  out  DATA_W  raw array contents at `dbgReg`, with no bypass.

## Operation
- State: `regs[0..2**ADDR_W-1]` (DATA_W each) and `busy[0..2**ADDR_W-1]` (1 bit each).
- Write: at posedge, if `regWrite`, then `regs[writeReg] <= writeData` and `busy[writeReg] <= 0`.
- Busy set: at posedge, if `busySet`, then `busy[busyReg] <= 1`.
- Simultaneous busy set and writeback to the same index: set wins, because a new producer supersedes the old one. The data write still happens.
- Zero register (`ZERO_REG`=1): writes to index 0 are discarded, `busySet` on index 0 is ignored, `readData` for index 0 is 0, and `readBusy` for index 0 is 0.
- Read port k, combinational: `readData_k = regs[readReg_k]`, subject to the bypass rule in Configuration. `readBusy_k = busy[readReg_k]`, also subject to that rule.
- Multiple ports may read the same index; each port is independent.
- `dbgData` is always the raw array value. It never reflects the bypass.

## Timing
- Read latency: 0 cycles (combinational from `readReg`, `regs`, `busy`, and the write inputs when bypass is on).
- Write latency: data is visible in the array after the posedge where `regWrite`=1.
- Busy latency: `readBusy` rises in the cycle after `busySet` is sampled.
- Reset: while `rstN`=0, all `regs` = 0 and all `busy` = 0, asynchronously, regardless of `clk`.
- Outputs under reset: `readData` = 0, `readBusy` = 0, `dbgData` = 0. Write and busy inputs are ignored.
- Reset release: the first accepted write or set is at the first posedge with `rstN`=1.
- Reset mid-write: the write is lost and the register reads 0.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through.
  - If `regWrite` and `writeReg == readReg_k` (and the index is non-zero when `ZERO_REG`=1), then `readData_k = writeData` and `readBusy_k = 0` in the same cycle, unless `busySet` targets the same index, in which case `readBusy_k = 1`.
  - The ID stage sees WB results without a forwarding path.
- `REGFILE_BYPASS_EN` undefined: reads return array contents only. A same-cycle write is visible one cycle later, and the external forwarding unit must cover the WB→ID case.

## Structure
- Package `regfile_pkg`: defaults `DATA_W_DEF`=32, `ADDR_W_DEF`=5, `N_READ_MAX`=4, and helper function `port_slice` (index extraction from the packed bus).
- Sub-module `regfile_rdport`: one instance per read port, generated `N_READ` times. It contains the array mux, zero-register masking, and the bypass compare/mux under `REGFILE_BYPASS_EN`.
- The top level holds the `regs`/`busy` arrays, write logic, busy update, reset and the debug port.

## Test plan
- Reset: drive `rstN`=0 after writing `r5`=0xDEADBEEF → `dbgData`(5)=0, all `readBusy`=0, with no clock edge needed.
- Write/read: write `r7`=0x12345678, then read port 0 at 7 and port 1 at 0 → 0x12345678 and 0. A write of 0xFFFFFFFF to `r0` → `r0` still reads 0.
- Bypass (macro on): `regWrite`=1, `writeReg`=3, `writeData`=0xA5A5A5A5, port 1 reads 3 in the same cycle → 0xA5A5A5A5 before the edge. With the macro off, port 1 returns the old value, then 0xA5A5A5A5 after the edge.
- Scoreboard: `busySet` `r9`, next cycle `readBusy`=1; write `r9`=0x55 → `readBusy`=0 after the edge, or in the same cycle with the macro on. `busySet` on `r0` → never busy.
- Simultaneous set and clear: `busySet` `r4` together with `regWrite` `r4`=0x77 → after the edge, `r4`=0x77 and `busy[4]`=1.
- Parameters: `N_READ`=4, `ADDR_W`=4, `DATA_W`=16, all four ports reading distinct and identical indices after writing `r15`=0xBEEF → every port matches `dbgData`.
